// File: rtl/mini_pkg.sv
// mini_pkg: types and constants shared by mini_module, its credit sender and mini_stream_rx.
//   outer_stream_s : beat payload carried on the mini stream
//   MINI_RX_DEPTH  : receive buffer depth, and the credit pool the sender starts with
package mini_pkg;

  localparam int unsigned MINI_RX_DEPTH = 4;
  localparam int unsigned TAG_W         = 4;
  localparam int unsigned CRED_W        = 8;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [CRED_W-1:0] cred;
  } outer_stream_s;

endpackage

// File: rtl/mini_rx_fifo.sv
// mini_rx_fifo: register-based circular FIFO with an occupancy counter.
//   clk, rst_n     : clock, asynchronous active-low reset
//   wr_en, wr_data : write one entry (caller guarantees not full, or a same-cycle read)
//   rd_en          : retire the head entry (caller guarantees not empty)
//   rd_data        : entry at the read pointer, read straight out of storage
//   count          : current occupancy
//   empty_c/full_c : decodes of count
module mini_rx_fifo #(
  parameter type         T     = logic [7:0],
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  T                 wr_data,
  input  logic             rd_en,
  output T                 rd_data,
  output logic [LVL_W-1:0] count,
  output logic             empty_c,
  output logic             full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;

  // Storage is cleared on reset so the head reads as zero while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_W'(1);
      if (rd_en) rptr <= rptr + PTR_W'(1);
    end
  end

  // Occupancy: simultaneous write and read leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (wr_en && !rd_en) begin
      count <= count + LVL_W'(1);
    end else if (rd_en && !wr_en) begin
      count <= count - LVL_W'(1);
    end
  end

  assign rd_data = mem[rptr];
  assign empty_c = (count == '0);
  assign full_c  = (count == LVL_W'(DEPTH));

endmodule

// File: rtl/mini_stream_rx.sv
// mini_stream_rx: credit-based receive buffer for the backpressure-free mini stream.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_stream, in_valid   : upstream beats (no ready; sender is credit-limited)
//   out_stream, out_valid : FIFO head and non-empty flag
//   out_ready             : consumer accepts the head
//   cred_return           : one pulse per credit handed back (DEPTH after reset)
//   level                 : current occupancy
//   err_overflow          : sticky, a beat arrived with no space and was dropped
//   err_clr               : clears err_overflow (a same-cycle overflow wins)
module mini_stream_rx
  import mini_pkg::*;
#(
  parameter int unsigned DEPTH = MINI_RX_DEPTH,
  parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  outer_stream_s    in_stream,
  input  logic             in_valid,
  output outer_stream_s    out_stream,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cred_return,
  output logic [LVL_W-1:0] level,
  output logic             err_overflow,
  input  logic             err_clr
);

  logic             empty_c;
  logic             full_c;
  logic             push_c;
  logic             pop_c;
  logic             ovf_c;
  logic             pend_nz_c;
  logic [LVL_W-1:0] pend;

  // A full FIFO still accepts a beat when the head leaves on the same edge.
  assign pop_c     = out_valid && out_ready;
  assign push_c    = in_valid && (!full_c || pop_c);
  assign ovf_c     = in_valid && full_c && !pop_c;
  assign out_valid = !empty_c;
  assign pend_nz_c = (pend != '0);

  mini_rx_fifo #(
    .T     (outer_stream_s),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_c),
    .wr_data (in_stream),
    .rd_en   (pop_c),
    .rd_data (out_stream),
    .count   (level),
    .empty_c (empty_c),
    .full_c  (full_c)
  );

  // Credits owed to the sender; starts at DEPTH so the full buffer is advertised.
  // One credit leaves per cycle, each pop adds one; the pool bounds pend to DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend        <= LVL_W'(DEPTH);
      cred_return <= 1'b0;
    end else begin
      pend        <= pend - LVL_W'(pend_nz_c) + LVL_W'(pop_c);
      cred_return <= pend_nz_c;
    end
  end

  // Sticky overflow flag; setting has priority over clearing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_overflow <= 1'b0;
    end else if (ovf_c) begin
      err_overflow <= 1'b1;
    end else if (err_clr) begin
      err_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mini_stream_rx.sv
// tb_mini_stream_rx: directed, table-driven bench for mini_stream_rx (DEPTH = 4).
module tb_mini_stream_rx;
  import mini_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  outer_stream_s    in_stream;
  logic             in_valid;
  outer_stream_s    out_stream;
  logic             out_valid;
  logic             out_ready;
  logic             cred_return;
  logic [LVL_W-1:0] level;
  logic             err_overflow;
  logic             err_clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mini_stream_rx #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_stream    (in_stream),
    .in_valid     (in_valid),
    .out_stream   (out_stream),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .cred_return  (cred_return),
    .level        (level),
    .err_overflow (err_overflow),
    .err_clr      (err_clr)
  );

  typedef struct {
    string      name;
    logic       iv;
    logic [7:0] ic;
    logic       ordy;
    logic       clr;
    logic       ev;
    logic       chk;
    logic [7:0] ec;
    int         elvl;
    logic       eerr;
    logic       ecr;
  } vec_t;

  vec_t vecs[$];

  function automatic outer_stream_s mk(input logic [7:0] c);
    outer_stream_s s;
    s.tag  = ~c[3:0];
    s.cred = c;
    return s;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string name, input logic iv, input logic [7:0] ic,
                     input logic ordy, input logic clr, input logic ev, input logic chk,
                     input logic [7:0] ec, input int elvl, input logic eerr, input logic ecr);
    vec_t v;
    v.name = name; v.iv = iv; v.ic = ic; v.ordy = ordy; v.clr = clr;
    v.ev = ev; v.chk = chk; v.ec = ec; v.elvl = elvl; v.eerr = eerr; v.ecr = ecr;
    vecs.push_back(v);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".out_valid"},   int'(out_valid), 0);
    check({tag, ".out_stream"},  int'(out_stream), 0);
    check({tag, ".level"},       int'(level), 0);
    check({tag, ".cred_return"}, int'(cred_return), 0);
    check({tag, ".err"},         int'(err_overflow), 0);
  endtask

  initial begin
    int credits;
    int sent;
    int rcvd;
    int pulses;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_stream = '0;
    out_ready = 1'b0;
    err_clr   = 1'b0;

    // Reset state, then release between edges and watch the initial credits.
    #3;
    check_zero("reset");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      check($sformatf("t1.cred%0d", i), int'(cred_return), (i <= 4) ? 1 : 0);
      check($sformatf("t1.valid%0d", i), int'(out_valid), 0);
      check($sformatf("t1.level%0d", i), int'(level), 0);
    end

    //   name          iv ic     rdy clr  ev chk ec    lvl err cr
    add("t2.push",     1, 8'h5A, 1, 0,    1, 1, 8'h5A, 1, 0, 0);
    add("t2.pop",      0, 8'h00, 1, 0,    0, 0, 8'h00, 0, 0, 0);
    add("t2.cred",     0, 8'h00, 0, 0,    0, 0, 8'h00, 0, 0, 1);
    add("t2.idle",     0, 8'h00, 0, 0,    0, 0, 8'h00, 0, 0, 0);
    add("t3.w0",       1, 8'hA0, 0, 0,    1, 1, 8'hA0, 1, 0, 0);
    add("t3.w1",       1, 8'hA1, 0, 0,    1, 1, 8'hA0, 2, 0, 0);
    add("t3.w2",       1, 8'hA2, 0, 0,    1, 1, 8'hA0, 3, 0, 0);
    add("t3.w3",       1, 8'hA3, 0, 0,    1, 1, 8'hA0, 4, 0, 0);
    add("t3.ovf",      1, 8'hA4, 0, 0,    1, 1, 8'hA0, 4, 1, 0);
    add("t3.hold",     0, 8'h00, 0, 0,    1, 1, 8'hA0, 4, 1, 0);
    add("t3.clr",      0, 8'h00, 0, 1,    1, 1, 8'hA0, 4, 0, 0);
    add("t3.setwins",  1, 8'hA5, 0, 1,    1, 1, 8'hA0, 4, 1, 0);
    add("t3.clr2",     0, 8'h00, 0, 1,    1, 1, 8'hA0, 4, 0, 0);
    add("t4.both",     1, 8'hB0, 1, 0,    1, 1, 8'hA1, 4, 0, 0);
    add("t4.cred",     0, 8'h00, 0, 0,    1, 1, 8'hA1, 4, 0, 1);
    add("t4.idle",     0, 8'h00, 0, 0,    1, 1, 8'hA1, 4, 0, 0);
    add("t4.d1",       0, 8'h00, 1, 0,    1, 1, 8'hA2, 3, 0, 0);
    add("t4.d2",       0, 8'h00, 1, 0,    1, 1, 8'hA3, 2, 0, 1);
    add("t4.d3",       0, 8'h00, 1, 0,    1, 1, 8'hB0, 1, 0, 1);
    add("t4.d4",       0, 8'h00, 1, 0,    0, 0, 8'h00, 0, 0, 1);
    add("t4.d5",       0, 8'h00, 0, 0,    0, 0, 8'h00, 0, 0, 1);
    add("t4.d6",       0, 8'h00, 0, 0,    0, 0, 8'h00, 0, 0, 0);

    foreach (vecs[k]) begin
      in_valid  = vecs[k].iv;
      in_stream = mk(vecs[k].ic);
      out_ready = vecs[k].ordy;
      err_clr   = vecs[k].clr;
      step();
      check({vecs[k].name, ".valid"}, int'(out_valid), int'(vecs[k].ev));
      if (vecs[k].chk)
        check({vecs[k].name, ".data"}, int'(out_stream), int'(mk(vecs[k].ec)));
      check({vecs[k].name, ".level"}, int'(level), vecs[k].elvl);
      check({vecs[k].name, ".err"}, int'(err_overflow), int'(vecs[k].eerr));
      check({vecs[k].name, ".cred"}, int'(cred_return), int'(vecs[k].ecr));
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    err_clr = 1'b0;

    // Fresh reset, then a credit-respecting sender of 10 beats against a toggling consumer.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    credits = 0; sent = 0; rcvd = 0; pulses = 0;
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (cred_return) begin
        pulses++;
        credits++;
      end
      out_ready = cyc[0];
      if (out_valid && out_ready) begin
        check($sformatf("t5.order%0d", rcvd), int'(out_stream), int'(mk(8'(rcvd))));
        rcvd++;
      end
      if (credits > 0 && sent < 10) begin
        in_valid  = 1'b1;
        in_stream = mk(8'(sent));
        credits--;
        sent++;
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("t5.received", rcvd, 10);
    check("t5.pulses", pulses, 14);
    check("t5.credits_back", credits, 4);
    check("t5.err", int'(err_overflow), 0);
    check("t5.level", int'(level), 0);

    // Level 3 with one credit pending, then an asynchronous reset mid-cycle.
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_stream = mk(8'hC0 + 8'(i));
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("t6.level3", int'(level), 3);
    check("t6.cred_pre", int'(cred_return), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t6.async");
    step();
    check_zero("t6.held");
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (cred_return) pulses++;
      check($sformatf("t6.cred%0d", i), int'(cred_return), (i <= 4) ? 1 : 0);
      check($sformatf("t6.stale%0d", i), int'(out_valid), 0);
    end
    check("t6.pulses", pulses, 4);
    check("t6.level", int'(level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
